// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: nibble width,
// FSM state encoding and nibble-counter sizing.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bits needed to count WIDTH/NIBBLE_W nibbles (never less than one).
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned n;
    n = width / NIBBLE_W;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_fa4.sv
// Existing 4-bit ripple-carry adder shared by the serial controller.
module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c[0] = cin;
    sum  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/sub that feeds one shared 4-bit adder a nibble
// per clock, low nibble first, chaining the carry through a register.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovfl
);

  localparam int unsigned CW      = cnt_width(WIDTH);
  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam logic [CW-1:0] LAST  = CW'(NIBBLES - 1);

  state_t state, state_next;

  logic [WIDTH-1:0]    a_q, b_q, result;
  logic                carry_q;
  logic [CW-1:0]       cnt;
  logic                accept;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign nib_a = a_q[cnt*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[cnt*NIBBLE_W +: NIBBLE_W];

  full_adder_4bit u_fa4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Subtraction stores ~B and seeds the carry with 1 (two's complement).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= sub ? ~B : B;
      carry_q <= sub;
      cnt     <= '0;
      result  <= '0;
    end else if (state == RUN) begin
      result[cnt*NIBBLE_W +: NIBBLE_W] <= nib_sum;
      carry_q                          <= nib_cout;
      cnt                              <= cnt + 1'b1;
    end
  end

  assign Sum  = result;
  assign Cout = carry_q;
  assign Ovfl = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [15:0] A, B;
  logic        busy, done, Cout, Ovfl;
  logic [15:0] Sum;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovfl  (Ovfl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for done (bounded); returns number of rising edges waited.
  task automatic wait_done(output int unsigned edges);
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] es,
                              input logic ec, input logic eo);
    check({tag, ".sum"},  32'(Sum),  32'(es));
    check({tag, ".cout"}, 32'(Cout), 32'(ec));
    check({tag, ".ovfl"}, 32'(Ovfl), 32'(eo));
  endtask

  // One operation; operands are scrambled right after acceptance to show
  // that only the latched values matter.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] es, input logic ec, input logic eo);
    int unsigned edges;
    @(negedge clk);
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy_after_e0"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0; A = ~a; B = a ^ b; sub = ~s;
    wait_done(edges);
    check({tag, ".latency"}, edges, 32'd4);
    check_result(tag, es, ec, eo);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle_busy"},  32'(busy), 32'd0);
    check({tag, ".sum_hold"},   32'(Sum),  32'(es));
  endtask

  initial begin
    int unsigned edges, seen;

    // Reset with start asserted on the same edge: reset wins.
    rst = 1'b1; start = 1'b1; sub = 1'b0; A = 16'h0003; B = 16'h0004;
    @(posedge clk); #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_result("rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.accept_next", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(edges);
    check("rst_op.latency", edges, 32'd4);
    check_result("rst_op", 16'h0007, 1'b0, 1'b0);
    @(posedge clk); #1;

    run_op("add_carry",  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovfl",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovfl",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_equal",  16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Start pulsed while busy with different operands: ignored.
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges);
    check_result("busy_start", 16'h2345, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("busy_start.no_queue", 32'(busy), 32'd0);

    // Start held high: back-to-back ops, done pulses 6 edges apart.
    @(negedge clk);
    A = 16'h4000; B = 16'h4000; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 16'h0F0F; B = 16'h00F1;
    wait_done(edges);
    check_result("held1", 16'h8000, 1'b0, 1'b1);
    @(posedge clk); #1;
    wait_done(edges);
    check("held.gap", edges + 1, 32'd6);
    check_result("held2", 16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset after E2 aborts the op; no done may follow.
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check_result("abort", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort.no_done", seen, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
